char_row_writer: RTL

CHAR_ROW_WRITER -- requirements
Module: char_row_writer

---
 rtl/char_row_writer.sv | 109 ++++++++++
 1 files changed

// File: rtl/char_row_writer.sv
// Character row writer: turns host command bytes into row-buffer cell writes,
// deferring every write until the display is blanked.
module char_row_writer #(
  parameter int         NUM_COLS   = 64,
  parameter logic [5:0] BLANK_CHAR = 6'b111111
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  input  logic       blank,
  output logic       wr_en,
  output logic [5:0] wr_addr,
  output logic [5:0] wr_data,
  output logic [5:0] cursor,
  output logic       busy
);

  localparam logic [5:0] LAST_COL = 6'(NUM_COLS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PEND_WR = 2'd1,
    CLEAR   = 2'd2
  } state_t;

  state_t     state;
  logic [5:0] pend_char;
  logic [5:0] clr_cnt;
  logic [1:0] opcode;
  logic [5:0] operand;
  logic [5:0] cursor_next;
  logic [5:0] cursor_load;

  assign opcode  = in_data[7:6];
  assign operand = in_data[5:0];

  // Held high during reset so the host never sees a stalled port while the FSM is being forced idle.
  assign in_ready = (state == IDLE) | ~rst_n;
  assign busy     = (state != IDLE);

  assign cursor_next = (cursor == LAST_COL) ? 6'd0 : cursor + 6'd1;
  assign cursor_load = ({1'b0, operand} >= 7'(NUM_COLS)) ? LAST_COL : operand;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      wr_en     <= 1'b0;
      wr_addr   <= 6'd0;
      wr_data   <= 6'd0;
      cursor    <= 6'd0;
      clr_cnt   <= 6'd0;
      pend_char <= 6'd0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            case (opcode)
              2'b00: begin
                pend_char <= operand;
                state     <= PEND_WR;
              end
              2'b01: cursor <= cursor_load;
              2'b10: begin
                clr_cnt <= 6'd0;
                state   <= CLEAR;
              end
              default: ;
            endcase
          end
        end
        PEND_WR: begin
          if (blank) begin
            wr_en   <= 1'b1;
            wr_addr <= cursor;
            wr_data <= pend_char;
            cursor  <= cursor_next;
            state   <= IDLE;
          end
        end
        CLEAR: begin
          // Counter only moves on blanked edges, so a clear stretches over as many frames as needed.
          if (blank) begin
            wr_en   <= 1'b1;
            wr_addr <= clr_cnt;
            wr_data <= BLANK_CHAR;
            if (clr_cnt == LAST_COL) begin
              clr_cnt <= 6'd0;
              cursor  <= 6'd0;
              state   <= IDLE;
            end else begin
              clr_cnt <= clr_cnt + 6'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_write_only_when_blank : assert property (
    @(posedge clk) disable iff (!rst_n) wr_en |-> $past(blank));

  a_ready_iff_idle : assert property (
    @(posedge clk) disable iff (!rst_n) in_ready == !busy);

endmodule
